// File: rtl/swipe_detector.sv
// swipe_detector
//   Four-direction swipe-gesture detector for the camera-tracking path. It keeps a DEPTH-entry
//   history of tracked centroids and compares every new valid sample with the oldest entry
//   (the sample DEPTH valid samples earlier). A large enough primary-axis move with little
//   off-axis drift produces a one-cycle direction event. After each event, motion is ignored
//   for COOLDOWN valid samples.
//
//   Optional build macro: SWIPE_STATS_EN adds four saturating 8-bit event counters.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   ready       sample valid; X_center/Y_center are meaningful this cycle
//   X_center    tracked centroid X (COORD_W bits, unsigned)
//   Y_center    tracked centroid Y (COORD_W bits, unsigned)
//   dir_valid   one-clock event pulse
//   dir_onehot  event direction: bit0 up, bit1 down, bit2 left, bit3 right (only with dir_valid)
//   dir_last    code of the most recent event (0 up, 1 down, 2 left, 3 right), held
//   busy        high while cooling down after an event
//   stats_clr   (SWIPE_STATS_EN) synchronous clear of the event counters; wins over increment
//   stats       (SWIPE_STATS_EN) {right, left, down, up} saturating 8-bit event counts
//
// Parameter constraints: DEPTH >= 1, COOLDOWN >= 1, DRIFT_TH <= MOVE_TH. The last constraint
// makes the four direction tests mutually exclusive; a fixed priority is kept anyway.

module swipe_detector #(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MOVE_TH  = 24,
  parameter int unsigned DRIFT_TH = 15,
  parameter int unsigned COOLDOWN = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic [COORD_W-1:0] X_center,
  input  logic [COORD_W-1:0] Y_center,
  output logic               dir_valid,
  output logic [3:0]         dir_onehot,
  output logic [1:0]         dir_last,
  output logic               busy
`ifdef SWIPE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        stats
`endif
);

  localparam int unsigned FillW = $clog2(DEPTH + 1);
  localparam int unsigned CoolW = $clog2(COOLDOWN + 1);

  localparam logic [FillW-1:0]   FillMax  = FillW'(DEPTH);
  localparam logic [CoolW-1:0]   CoolInit = CoolW'(COOLDOWN);
  localparam logic [CoolW-1:0]   CoolLast = CoolW'(1);
  localparam logic [COORD_W-1:0] MoveTh   = COORD_W'(MOVE_TH);
  localparam logic [COORD_W-1:0] DriftTh  = COORD_W'(DRIFT_TH);

  // Direction codes as presented on dir_last.
  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  typedef enum logic [1:0] {
    StFill,
    StArmed,
    StCool
  } state_e;

  state_e             state_q;
  logic [FillW-1:0]   fill_cnt_q;
  logic [CoolW-1:0]   cool_cnt_q;

  // Entry 0 is the newest sample, entry DEPTH-1 the oldest.
  logic [COORD_W-1:0] hist_x_q [DEPTH];
  logic [COORD_W-1:0] hist_y_q [DEPTH];

  // ---------------------------------------------------------------------------------------------
  // Displacement and direction decode against the oldest history entry
  // ---------------------------------------------------------------------------------------------
  logic [COORD_W-1:0] x_old, y_old;
  logic [COORD_W-1:0] dx, dy;
  logic               x_inc, x_dec, y_inc, y_dec;
  logic               hit_up, hit_down, hit_left, hit_right;
  logic               hit;
  logic [1:0]         hit_code;
  logic [3:0]         hit_onehot;

  always_comb begin
    x_old = hist_x_q[DEPTH-1];
    y_old = hist_y_q[DEPTH-1];

    x_inc = X_center > x_old;
    x_dec = X_center < x_old;
    y_inc = Y_center > y_old;
    y_dec = Y_center < y_old;

    // Larger minus smaller, so the magnitude never wraps.
    dx = x_inc ? (X_center - x_old) : (x_old - X_center);
    dy = y_inc ? (Y_center - y_old) : (y_old - Y_center);

    hit_down  = y_inc && (dy > MoveTh) && (dx < DriftTh);
    hit_up    = y_dec && (dy > MoveTh) && (dx < DriftTh);
    hit_right = x_inc && (dx > MoveTh) && (dy < DriftTh);
    hit_left  = x_dec && (dx > MoveTh) && (dy < DriftTh);

    hit      = hit_down || hit_up || hit_right || hit_left;
    hit_code = DirUp;
    if (hit_down) begin
      hit_code = DirDown;
    end else if (hit_up) begin
      hit_code = DirUp;
    end else if (hit_right) begin
      hit_code = DirRight;
    end else if (hit_left) begin
      hit_code = DirLeft;
    end

    hit_onehot = 4'b0000;
    unique case (hit_code)
      DirUp:    hit_onehot = 4'b0001;
      DirDown:  hit_onehot = 4'b0010;
      DirLeft:  hit_onehot = 4'b0100;
      DirRight: hit_onehot = 4'b1000;
      default:  hit_onehot = 4'b0000;
    endcase
  end

  // An event is taken only on a valid sample while armed.
  logic fire;
  assign fire = ready && (state_q == StArmed) && hit;

  // ---------------------------------------------------------------------------------------------
  // History shift register: advances on valid samples only, in every state
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        hist_x_q[i] <= '0;
        hist_y_q[i] <= '0;
      end
    end else if (ready) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        hist_x_q[i] <= hist_x_q[i-1];
        hist_y_q[i] <= hist_y_q[i-1];
      end
      hist_x_q[0] <= X_center;
      hist_y_q[0] <= Y_center;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      cool_cnt_q <= '0;
      dir_valid  <= 1'b0;
      dir_onehot <= 4'b0000;
      dir_last   <= DirUp;
      busy       <= 1'b0;
    end else begin
      // Event outputs are pulses; they fall back to zero unless refreshed below.
      dir_valid  <= 1'b0;
      dir_onehot <= 4'b0000;

      if (ready) begin
        unique case (state_q)
          StFill: begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            // The sample that completes the history is stored but not evaluated.
            if (fill_cnt_q + 1'b1 == FillMax) begin
              state_q <= StArmed;
            end
          end

          StArmed: begin
            if (fire) begin
              dir_valid  <= 1'b1;
              dir_onehot <= hit_onehot;
              dir_last   <= hit_code;
              busy       <= 1'b1;
              cool_cnt_q <= CoolInit;
              state_q    <= StCool;
            end
          end

          StCool: begin
            cool_cnt_q <= cool_cnt_q - 1'b1;
            // Counter reaching zero re-arms on this edge; the next valid sample is evaluated.
            if (cool_cnt_q == CoolLast) begin
              busy    <= 1'b0;
              state_q <= StArmed;
            end
          end

          default: begin
            state_q <= StFill;
          end
        endcase
      end
    end
  end

`ifdef SWIPE_STATS_EN
  // ---------------------------------------------------------------------------------------------
  // Saturating per-direction event counters, indexed by direction code
  // ---------------------------------------------------------------------------------------------
  logic [3:0][7:0] stats_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stats_q <= '0;
    end else if (stats_clr) begin
      stats_q <= '0;
    end else if (fire && (stats_q[hit_code] != 8'hff)) begin
      stats_q[hit_code] <= stats_q[hit_code] + 8'd1;
    end
  end

  assign stats = stats_q;
`endif

endmodule

// File: doc/swipe_detector.md
Name: swipe_detector

Overview:
- Parametrised four-direction swipe-gesture detector for the camera-tracking path. Sits between the object-centroid tracker and the game-control FSM.
- Keeps a DEPTH-sample history of tracked (X,Y) centroids and compares each new sample against the oldest entry.
- On a qualifying move, emits a one-cycle up/down/left/right event, then ignores motion for a programmable cooldown.
- Generalises the single-direction down-swipe detector: configurable width, history depth, thresholds and cooldown; history advances on valid samples only; detection is gated until the history is full.

Parameters:
- COORD_W, 10, coordinate width in bits.
- DEPTH, 4, history length in valid samples (>=1).
- MOVE_TH, 24, primary-axis displacement must be strictly greater than this.
- DRIFT_TH, 15, off-axis displacement must be strictly less than this. Requires DRIFT_TH <= MOVE_TH.
- COOLDOWN, 6, number of valid samples ignored after an event (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ready  in  1  sample valid; X_center/Y_center are meaningful this cycle
- X_center  in  COORD_W  tracked centroid X
- Y_center  in  COORD_W  tracked centroid Y
- dir_valid  out  1  one-clock event pulse
- dir_onehot  out  4  event direction; bit0 up, bit1 down, bit2 left, bit3 right; nonzero only with dir_valid
- dir_last  out  2  code of most recent event (0 up, 1 down, 2 left, 3 right); held between events
- busy  out  1  high while in COOLDOWN

Behaviour:
- Reset:
  - All outputs are 0.
  - History registers are 0.
  - Fill counter is 0.
  - State is FILL.
  - Reset asserted mid-cooldown or mid-fill aborts immediately; after release the block refills from empty.
- Cycles with ready=0:
  - No state change: history, fill count and cooldown are frozen.
  - dir_valid=0 and dir_onehot=0.
- Cycles with ready=1:
  - The history shifts by one: entry0 takes the new sample, entry DEPTH-1 is discarded.
  - Comparison uses the new sample against the pre-shift entry DEPTH-1 (the sample DEPTH valid samples earlier).
- Displacement:
  - dx = |X_center - Xold| and dy = |Y_center - Yold|, computed in COORD_W bits with no wrap (subtract larger minus smaller).
  - down: Y_center>Yold, dy>MOVE_TH, dx<DRIFT_TH.
  - up: Y_center<Yold, dy>MOVE_TH, dx<DRIFT_TH.
  - right: X_center>Xold, dx>MOVE_TH, dy<DRIFT_TH.
  - left: X_center<Xold, dx>MOVE_TH, dy<DRIFT_TH.
  - The parameter constraint makes these mutually exclusive; the fixed priority down>up>right>left is still implemented.
- FSM states:
  - FILL: counts valid samples. Moves to ARMED on the valid sample that makes count==DEPTH. No detection is evaluated on that sample.
  - ARMED: each valid sample is evaluated. On a hit:
    - next clock: dir_valid=1, dir_onehot set, dir_last updated, busy=1.
    - cooldown counter loads COOLDOWN; state goes to COOLDOWN.
  - COOLDOWN:
    - Each valid sample decrements the counter and is never evaluated.
    - When the counter reaches 0, state returns to ARMED and busy drops on the same clock edge.
    - The next valid sample is then evaluated.
    - History keeps shifting throughout, so no refill is needed.
- Latency: event is registered exactly 1 clock after the qualifying ready cycle.
- dir_valid is high for exactly one clock per event.
- Cooldown counter width is $clog2(COOLDOWN+1).

Optional Feature:
- Macro: SWIPE_STATS_EN.
- When defined:
  - Adds output port stats (32 bits): four 8-bit saturating event counters. [7:0] up, [15:8] down, [23:16] left, [31:24] right.
  - Each counter increments on the same clock as dir_valid and holds at 255.
  - Counters clear on reset.
  - Adds input stats_clr (1 bit): synchronous clear of all counters. Clear wins over a simultaneous increment.
- When undefined: neither port exists, and no counter logic is present.

Test Plan:
- Defaults; reset, then 4 valid samples (320,100), then (325,130) -> next clock dir_valid=1, dir_onehot=0010, dir_last=1, busy=1.
- Reset; 3 valid samples (320,100), then (320,200) -> no event (still FILL); the 5th sample (320,240) vs oldest (320,100) -> down event.
- Armed at (320,100); sample dy=24, dx=0 -> none. Sample dy=25, dx=14 -> down. Sample dy=30, dx=15 -> none. Repeat for X with 2->left/right.
- After an event, 6 further qualifying down samples -> no events and busy high. The 7th qualifying sample -> event. busy low for exactly that evaluation cycle.
- Armed; ready toggled 1,0,0,1 with a qualifying move split across the gaps -> history and cooldown frozen during ready=0; event timing counts only ready cycles. Reset mid-cooldown -> busy=0, dir_last=0, FILL.
- With SWIPE_STATS_EN: 300 right events -> stats[31:24]=255. stats_clr coincident with an event -> 0.
